// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/capture stage around a combinational ripple ALU.
// Accepts one (A, B, cmd) operation per input handshake, holds the ALU operands
// stable for SETTLE_CYCLES clocks, captures result and masked flags, and
// presents them on an output valid/ready handshake.
// Optional build macro: ALU_SEQ_STICKY_OVF_EN adds ovf_clear / ovf_sticky.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 4,   // 1..15
    parameter int WIDTH         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_cmd,
    output logic             out_carryout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             busy
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    input  logic             ovf_clear,
    output logic             ovf_sticky
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] CMD_ADD    = 3'd0;
    localparam logic [2:0] CMD_SUB    = 3'd1;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_count;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2:0]         r_alu_cmd;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_result;
    logic [2:0]         r_out_cmd;
    logic               r_out_carryout;
    logic               r_out_overflow;
    logic               r_out_zero;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_capture;
    logic               w_release;
    logic               w_arith;
    logic               w_carry_masked;
    logic               w_ovf_masked;

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_count == 4'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = in_valid ? ST_SETTLE : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    // Carry and overflow are only meaningful for the arithmetic commands
    assign w_arith        = (r_alu_cmd == CMD_ADD) || (r_alu_cmd == CMD_SUB);
    assign w_carry_masked = w_arith & alu_carryout;
    assign w_ovf_masked   = w_arith & alu_overflow;

    // State, operand issue, settle counter and result capture registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_count        <= 4'd0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_cmd      <= 3'd0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_cmd      <= 3'd0;
            r_out_carryout <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_alu_a   <= in_a;
                r_alu_b   <= in_b;
                r_alu_cmd <= in_cmd;
                r_count   <= COUNT_LOAD;
            end else if ((r_state == ST_SETTLE) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end

            if (w_capture) begin
                r_out_valid    <= 1'b1;
                r_out_result   <= alu_result;
                r_out_cmd      <= r_alu_cmd;
                r_out_carryout <= w_carry_masked;
                r_out_overflow <= w_ovf_masked;
                r_out_zero     <= (alu_result == '0);
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_OVF_EN
    logic r_ovf_sticky;

    // Sticky overflow: a capture with overflow takes priority over a clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_capture && w_ovf_masked) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

    assign in_ready     = w_in_ready;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_cmd      = r_alu_cmd;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_cmd      = r_out_cmd;
    assign out_carryout = r_out_carryout;
    assign out_overflow = r_out_overflow;
    assign out_zero     = r_out_zero;
    assign busy         = (r_state != ST_IDLE);

endmodule
